// File: rtl/rpc2_ctrl_trans_arbiter_if.sv
// Purpose: bundles the read/write request, grant and status signals of the transaction arbiter.
// Latency: none, this is wiring only.
// Backpressure: requests are levels held until their grant; the engine signals completion with trans_done.
interface rpc2_ctrl_trans_arbiter_if;
  logic [1:0] reg_rd_trans_alloc;
  logic [1:0] reg_wr_trans_alloc;
  logic       rd_req;
  logic       wr_req;
  logic       trans_done;
  logic       rd_gnt;
  logic       wr_gnt;
  logic       arb_busy;
  logic       arb_sel_wr;
  logic       tmo_err;

  // Requester/engine side: drives requests, weights and completion, observes grants.
  modport master (
    output reg_rd_trans_alloc, reg_wr_trans_alloc, rd_req, wr_req, trans_done,
    input  rd_gnt, wr_gnt, arb_busy, arb_sel_wr, tmo_err
  );

  // Arbiter side.
  modport slave (
    input  reg_rd_trans_alloc, reg_wr_trans_alloc, rd_req, wr_req, trans_done,
    output rd_gnt, wr_gnt, arb_busy, arb_sel_wr, tmo_err
  );
endinterface

// File: rtl/rpc2_ctrl_trans_arbiter.sv
// Purpose: weighted read/write arbiter that shares one transaction engine, one transaction at a time.
// Latency: the grant pulse is registered, one cycle after an IDLE decision; IDLE one cycle after trans_done.
// Backpressure: requests wait while a transaction is outstanding; an optional watchdog aborts a hung one.
module rpc2_ctrl_trans_arbiter #(
  parameter int unsigned TMO_CYCLES = 1024,
  parameter int unsigned TMO_WIDTH  = 16
) (
  input  logic                     AXIm_ACLK,
  input  logic                     AXIm_ARESET,
  rpc2_ctrl_trans_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  // Last watchdog count before an abort; unused when the watchdog is off.
  localparam logic [TMO_WIDTH-1:0] TMO_LAST =
    TMO_WIDTH'((TMO_CYCLES == 0) ? 0 : (TMO_CYCLES - 1));

  state_t               state, state_nxt;
  logic                 phase, phase_nxt;          // side owning the current turn, 1 = write
  logic [2:0]           rd_cred, rd_cred_nxt;      // grants left in the read turn
  logic [2:0]           wr_cred, wr_cred_nxt;      // grants left in the write turn
  logic [TMO_WIDTH-1:0] tmo_cnt, tmo_cnt_nxt;
  logic                 rd_gnt_q, rd_gnt_nxt;
  logic                 wr_gnt_q, wr_gnt_nxt;
  logic                 sel_wr_q, sel_wr_nxt;
  logic                 tmo_err_q, tmo_err_nxt;

  logic                 req_p, req_o;
  logic [2:0]           cred_p;
  logic                 gnt_any, gnt_wr, reload;
  logic                 tmo_expire;

  // Requests and credit seen from the point of view of the side owning the turn.
  assign req_p  = phase ? bus.wr_req : bus.rd_req;
  assign req_o  = phase ? bus.rd_req : bus.wr_req;
  assign cred_p = phase ? wr_cred : rd_cred;

  assign tmo_expire = (TMO_CYCLES != 0) && (tmo_cnt == TMO_LAST);

  // Grant decision in IDLE, completion/watchdog handling in BUSY.
  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    rd_cred_nxt = rd_cred;
    wr_cred_nxt = wr_cred;
    tmo_cnt_nxt = tmo_cnt;
    rd_gnt_nxt  = 1'b0;
    wr_gnt_nxt  = 1'b0;
    sel_wr_nxt  = sel_wr_q;
    tmo_err_nxt = 1'b0;
    gnt_any     = 1'b0;
    gnt_wr      = 1'b0;
    reload      = 1'b0;

    unique case (state)
      IDLE: begin
        if (req_p && (cred_p != 3'd0)) begin
          // Continue the current turn.
          gnt_any = 1'b1;
          gnt_wr  = phase;
        end else if (req_o) begin
          // Turn passes to the other side with a fresh weight.
          gnt_any   = 1'b1;
          gnt_wr    = ~phase;
          reload    = 1'b1;
          phase_nxt = ~phase;
        end else if (req_p) begin
          // Uncontended: the current side starts a new turn of its own.
          gnt_any = 1'b1;
          gnt_wr  = phase;
          reload  = 1'b1;
        end

        if (gnt_any) begin
          // Reload leaves alloc grants, because this grant is one of the alloc+1.
          if (gnt_wr) begin
            wr_cred_nxt = reload ? {1'b0, bus.reg_wr_trans_alloc} : (wr_cred - 3'd1);
          end else begin
            rd_cred_nxt = reload ? {1'b0, bus.reg_rd_trans_alloc} : (rd_cred - 3'd1);
          end
          state_nxt   = BUSY;
          tmo_cnt_nxt = '0;
          rd_gnt_nxt  = ~gnt_wr;
          wr_gnt_nxt  = gnt_wr;
          sel_wr_nxt  = gnt_wr;
        end
      end

      BUSY: begin
        if (bus.trans_done) begin
          // Completion beats a simultaneous watchdog expiry.
          state_nxt = IDLE;
        end else if (tmo_expire) begin
          state_nxt   = IDLE;
          tmo_err_nxt = 1'b1;
        end else if (TMO_CYCLES != 0) begin
          tmo_cnt_nxt = tmo_cnt + TMO_WIDTH'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State, credits and registered outputs; reset drops any ownership silently.
  always_ff @(posedge AXIm_ACLK or posedge AXIm_ARESET) begin
    if (AXIm_ARESET) begin
      state     <= IDLE;
      phase     <= 1'b1;
      rd_cred   <= 3'd0;
      wr_cred   <= 3'd0;
      tmo_cnt   <= '0;
      rd_gnt_q  <= 1'b0;
      wr_gnt_q  <= 1'b0;
      sel_wr_q  <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      rd_cred   <= rd_cred_nxt;
      wr_cred   <= wr_cred_nxt;
      tmo_cnt   <= tmo_cnt_nxt;
      rd_gnt_q  <= rd_gnt_nxt;
      wr_gnt_q  <= wr_gnt_nxt;
      sel_wr_q  <= sel_wr_nxt;
      tmo_err_q <= tmo_err_nxt;
    end
  end

  assign bus.rd_gnt     = rd_gnt_q;
  assign bus.wr_gnt     = wr_gnt_q;
  assign bus.arb_busy   = (state == BUSY);
  assign bus.arb_sel_wr = sel_wr_q;
  assign bus.tmo_err    = tmo_err_q;

endmodule

// File: tb/tb_rpc2_ctrl_trans_arbiter.sv
// Purpose: directed self-checking bench for the weighted read/write transaction arbiter.
// Latency: grant sides are queued when requests are driven and popped when a grant pulse appears.
// Backpressure: every wait for a grant is bounded by a cycle budget.
`timescale 1ns/1ps
module tb_rpc2_ctrl_trans_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rpc2_ctrl_trans_arbiter_if bus ();

  rpc2_ctrl_trans_arbiter #(
    .TMO_CYCLES(8),
    .TMO_WIDTH (16)
  ) dut (
    .AXIm_ACLK  (clk),
    .AXIm_ARESET(rst),
    .bus        (bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   rd_cnt = 0;
  logic exp_q[$];          // expected grant side, 1 = write
  logic prev_busy = 1'b0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Every grant must be one-hot and must follow a cycle with no transaction outstanding.
  always @(negedge clk) begin
    if (!rst && (bus.rd_gnt || bus.wr_gnt)) begin
      chk("gnt_onehot", bus.rd_gnt & bus.wr_gnt, 1'b0);
      chk("gnt_while_busy", prev_busy, 1'b0);
    end
    if (bus.rd_gnt) rd_cnt++;
    prev_busy = bus.arb_busy;
  end

  task automatic wait_gnt(output logic side, output logic ok);
    ok   = 1'b0;
    side = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.rd_gnt || bus.wr_gnt) begin
        ok   = 1'b1;
        side = bus.wr_gnt;
      end
    end
    if (!ok) chk("gnt_timeout", 1'b0, 1'b1);
  endtask

  // Wait for a grant, score it, then signal completion dly cycles after the grant cycle.
  task automatic do_txn(input int dly, input string tag);
    logic side, ok, e;
    wait_gnt(side, ok);
    if (ok) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_unexpected"}, 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk({tag, "_side"}, side, e);
        chk({tag, "_sel"}, bus.arb_sel_wr, e);
      end
      chk({tag, "_busy"}, bus.arb_busy, 1'b1);
    end
    repeat (dly) @(negedge clk);
    bus.trans_done = 1'b1;
    @(negedge clk);
    bus.trans_done = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    bus.trans_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic side, ok;
    int   rd_start;

    rst = 1'b1;
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    bus.trans_done = 1'b0;
    bus.reg_rd_trans_alloc = 2'd0;
    bus.reg_wr_trans_alloc = 2'd0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_rd_gnt", bus.rd_gnt, 1'b0);
    chk("rst_wr_gnt", bus.wr_gnt, 1'b0);
    chk("rst_busy", bus.arb_busy, 1'b0);
    chk("rst_sel_wr", bus.arb_sel_wr, 1'b0);
    chk("rst_tmo_err", bus.tmo_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Continuous contention, alloc rd=1 wr=0: R,R,W repeating, read first.
    bus.reg_rd_trans_alloc = 2'd1;
    bus.reg_wr_trans_alloc = 2'd0;
    bus.rd_req = 1'b1;
    bus.wr_req = 1'b1;
    exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    for (int i = 0; i < 6; i++) do_txn(3, "contend");
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;

    // Write-only traffic with alloc_wr=0: every grant is a write.
    reset_dut();
    bus.reg_rd_trans_alloc = 2'd3;
    bus.reg_wr_trans_alloc = 2'd0;
    rd_start = rd_cnt;
    bus.wr_req = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(1'b1);
    for (int i = 0; i < 4; i++) do_txn(1, "wr_only");
    bus.wr_req = 1'b0;
    chk("wr_only_no_rd", rd_cnt != rd_start, 1'b0);

    // Exact busy window and earliest regrant after trans_done.
    reset_dut();
    bus.wr_req = 1'b1;
    exp_q.push_back(1'b1);
    wait_gnt(side, ok);
    if (ok) chk("win_side", side, exp_q.pop_front());
    chk("win_busy_g", bus.arb_busy, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("win_busy_mid", bus.arb_busy, 1'b1);
      chk("win_no_regrant", bus.wr_gnt, 1'b0);
    end
    @(negedge clk);
    chk("win_busy_done", bus.arb_busy, 1'b1);
    bus.trans_done = 1'b1;
    @(negedge clk);
    bus.trans_done = 1'b0;
    chk("win_idle", bus.arb_busy, 1'b0);
    chk("win_gap", bus.wr_gnt, 1'b0);
    @(negedge clk);
    chk("win_regrant", bus.wr_gnt, 1'b1);
    chk("win_busy_again", bus.arb_busy, 1'b1);
    bus.wr_req = 1'b0;
    bus.trans_done = 1'b1;
    @(negedge clk);
    bus.trans_done = 1'b0;
    @(negedge clk);

    // Watchdog: no trans_done, abort 8 cycles after the grant, then the waiting read is granted.
    reset_dut();
    bus.wr_req = 1'b1;
    wait_gnt(side, ok);
    if (ok) chk("tmo_first_side", side, 1'b1);
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      chk("tmo_early", bus.tmo_err, 1'b0);
      chk("tmo_busy", bus.arb_busy, 1'b1);
    end
    @(negedge clk);
    chk("tmo_pulse", bus.tmo_err, 1'b1);
    chk("tmo_idle", bus.arb_busy, 1'b0);
    @(negedge clk);
    chk("tmo_pulse_end", bus.tmo_err, 1'b0);
    chk("tmo_next_rd", bus.rd_gnt, 1'b1);
    bus.rd_req = 1'b0;
    bus.trans_done = 1'b1;
    @(negedge clk);
    bus.trans_done = 1'b0;

    // trans_done in the expiry cycle wins: no abort pulse.
    reset_dut();
    bus.wr_req = 1'b1;
    wait_gnt(side, ok);
    bus.wr_req = 1'b0;
    repeat (7) @(negedge clk);
    bus.trans_done = 1'b1;
    @(negedge clk);
    bus.trans_done = 1'b0;
    chk("race_no_tmo", bus.tmo_err, 1'b0);
    chk("race_idle", bus.arb_busy, 1'b0);
    @(negedge clk);
    chk("race_no_tmo_late", bus.tmo_err, 1'b0);

    // alloc_rd 1 -> 3 mid read turn: turn finishes with 2 reads, next read turn gives 4.
    reset_dut();
    bus.reg_rd_trans_alloc = 2'd1;
    bus.reg_wr_trans_alloc = 2'd0;
    bus.rd_req = 1'b1;
    bus.wr_req = 1'b1;
    exp_q.push_back(1'b0);
    do_txn(2, "alloc_old");
    bus.reg_rd_trans_alloc = 2'd3;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    for (int i = 0; i < 4; i++) exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    for (int i = 0; i < 7; i++) do_txn(2, "alloc_new");
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;

    // Reset while BUSY clears outputs at once; contention afterwards grants read first.
    reset_dut();
    bus.wr_req = 1'b1;
    wait_gnt(side, ok);
    bus.wr_req = 1'b0;
    @(negedge clk);
    chk("mid_pre_busy", bus.arb_busy, 1'b1);
    chk("mid_pre_sel", bus.arb_sel_wr, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", bus.arb_busy, 1'b0);
    chk("mid_rst_sel", bus.arb_sel_wr, 1'b0);
    chk("mid_rst_rd_gnt", bus.rd_gnt, 1'b0);
    chk("mid_rst_wr_gnt", bus.wr_gnt, 1'b0);
    chk("mid_rst_tmo", bus.tmo_err, 1'b0);
    bus.reg_rd_trans_alloc = 2'd0;
    bus.reg_wr_trans_alloc = 2'd0;
    bus.rd_req = 1'b1;
    bus.wr_req = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    do_txn(1, "post_rst");
    do_txn(1, "post_rst");
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    repeat (3) @(negedge clk);

    chk("queue_drained", exp_q.size() != 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
